// File: rtl/risc32_wb_pipe_stage.sv
// MEM/WB pipeline register with stall/flush control, architectural HI/LO
// with same-cycle bypass from the WB slot, and a retired-instruction counter.
module risc32_wb_pipe_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         stall_i,
  input  logic               flush_i,
  input  logic               mem_valid_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic               mem_wreg_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic [DATA_W-1:0]  mem_hi_i,
  input  logic [DATA_W-1:0]  mem_lo_i,
  input  logic               mem_whilo_i,
  output logic               wb_valid_o,
  output logic [RADDR_W-1:0] wb_wd_o,
  output logic               wb_wreg_o,
  output logic [DATA_W-1:0]  wb_wdata_o,
  output logic [DATA_W-1:0]  wb_hi_o,
  output logic [DATA_W-1:0]  wb_lo_o,
  output logic               wb_whilo_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o,
  output logic [CNT_W-1:0]   retired_o
);

  logic              load_bubble;
  logic              capture;
  logic              commit;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;

  // Stage-register control decode; stall 2'b10 falls through to capture.
  always_comb begin
    load_bubble = flush_i | (stall_i == 2'b01);
    capture     = ~stall_i[0];
    commit      = wb_valid_o & ~stall_i[1];
  end

  // MEM/WB pipeline register: flush/bubble, capture or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_o <= 1'b0;
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
      wb_hi_o    <= '0;
      wb_lo_o    <= '0;
      wb_whilo_o <= 1'b0;
    end else if (load_bubble) begin
      wb_valid_o <= 1'b0;
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
      wb_hi_o    <= '0;
      wb_lo_o    <= '0;
      wb_whilo_o <= 1'b0;
    end else if (capture) begin
      wb_valid_o <= mem_valid_i;
      wb_wd_o    <= mem_wd_i;
      wb_wreg_o  <= mem_wreg_i & mem_valid_i;
      wb_wdata_o <= mem_wdata_i;
      wb_hi_o    <= mem_hi_i;
      wb_lo_o    <= mem_lo_i;
      wb_whilo_o <= mem_whilo_i & mem_valid_i;
    end
  end

  // Architectural HI/LO and retire counter update on commit, flush or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      retired_o <= '0;
    end else if (commit) begin
      retired_o <= retired_o + CNT_W'(1);
      if (wb_whilo_o) begin
        hi_reg <= wb_hi_o;
        lo_reg <= wb_lo_o;
      end
    end
  end

  // Bypass pending HI/LO write ahead of the architectural value.
  always_comb begin
    hi_o = wb_whilo_o ? wb_hi_o : hi_reg;
    lo_o = wb_whilo_o ? wb_lo_o : lo_reg;
  end

endmodule

// File: tb/tb_risc32_wb_pipe_stage.sv
// Self-checking bench: directed test-plan steps plus randomized traffic
// compared against an instruction-level model of the WB slot and HI/LO.
module tb_risc32_wb_pipe_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;

  logic        wb_valid, wb_wreg, wb_whilo;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata, wb_hi, wb_lo, hi, lo, retired;

  logic        d4_valid, d4_wreg, d4_whilo;
  logic [4:0]  d4_wd;
  logic [31:0] d4_wdata, d4_hi_p, d4_lo_p, d4_hi, d4_lo;
  logic [3:0]  d4_retired;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction sitting in WB and architectural state.
  logic        m_valid, m_wreg, m_whilo;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata, m_hi, m_lo, m_hireg, m_loreg;
  longint      m_commits;

  risc32_wb_pipe_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_wd_i(mem_wd), .mem_wreg_i(mem_wreg),
    .mem_wdata_i(mem_wdata), .mem_hi_i(mem_hi), .mem_lo_i(mem_lo),
    .mem_whilo_i(mem_whilo),
    .wb_valid_o(wb_valid), .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg),
    .wb_wdata_o(wb_wdata), .wb_hi_o(wb_hi), .wb_lo_o(wb_lo),
    .wb_whilo_o(wb_whilo), .hi_o(hi), .lo_o(lo), .retired_o(retired)
  );

  risc32_wb_pipe_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_wd_i(mem_wd), .mem_wreg_i(mem_wreg),
    .mem_wdata_i(mem_wdata), .mem_hi_i(mem_hi), .mem_lo_i(mem_lo),
    .mem_whilo_i(mem_whilo),
    .wb_valid_o(d4_valid), .wb_wd_o(d4_wd), .wb_wreg_o(d4_wreg),
    .wb_wdata_o(d4_wdata), .wb_hi_o(d4_hi_p), .wb_lo_o(d4_lo_p),
    .wb_whilo_o(d4_whilo), .hi_o(d4_hi), .lo_o(d4_lo), .retired_o(d4_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_wreg = 0; m_whilo = 0; m_wd = '0;
    m_wdata = '0; m_hi = '0; m_lo = '0; m_hireg = '0; m_loreg = '0;
    m_commits = 0;
  endtask

  task automatic check_all();
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] c32;
    logic [3:0]  c4;
    exp_hi = m_whilo ? m_hi : m_hireg;
    exp_lo = m_whilo ? m_lo : m_loreg;
    c32 = 32'(m_commits);
    c4  = 4'(m_commits);
    chk("wb_valid", 64'(wb_valid), 64'(m_valid));
    chk("wb_wd",    64'(wb_wd),    64'(m_wd));
    chk("wb_wreg",  64'(wb_wreg),  64'(m_wreg));
    chk("wb_wdata", 64'(wb_wdata), 64'(m_wdata));
    chk("wb_hi",    64'(wb_hi),    64'(m_hi));
    chk("wb_lo",    64'(wb_lo),    64'(m_lo));
    chk("wb_whilo", 64'(wb_whilo), 64'(m_whilo));
    chk("hi",       64'(hi),       64'(exp_hi));
    chk("lo",       64'(lo),       64'(exp_lo));
    chk("retired",  64'(retired),  64'(c32));
    chk("d4_retired", 64'(d4_retired), 64'(c4));
    chk("d4_hi",    64'(d4_hi),    64'(exp_hi));
  endtask

  // One clock edge: inputs already driven; model advances; outputs checked after the edge.
  task automatic cycle();
    assert (stall !== 2'b10) else begin
      errors++;
      $error("FAIL illegal_stall observed=%b expected=not 10", stall);
    end
    if (m_valid && !stall[1]) begin
      m_commits++;
      if (m_whilo) begin
        m_hireg = m_hi;
        m_loreg = m_lo;
      end
    end
    if (flush || stall == 2'b01) begin
      m_valid = 0; m_wd = '0; m_wreg = 0; m_wdata = '0;
      m_hi = '0; m_lo = '0; m_whilo = 0;
    end else if (stall != 2'b11) begin
      m_valid = mem_valid; m_wd = mem_wd; m_wreg = mem_wreg & mem_valid;
      m_wdata = mem_wdata; m_hi = mem_hi; m_lo = mem_lo;
      m_whilo = mem_whilo & mem_valid;
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wr,
                       input logic [31:0] wdat, input logic [31:0] h,
                       input logic [31:0] l, input logic whl);
    mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
    mem_hi = h; mem_lo = l; mem_whilo = whl;
  endtask

  // Asynchronous reset pulse between edges, outputs checked before any clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 2'b00;
    flush = 1'b0;
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Basic capture and retire.
    drive(1, 5'd5, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    cycle();
    chk("t1_wd", 64'(wb_wd), 64'd5);
    chk("t1_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    chk("t1_valid", 64'(wb_valid), 64'd1);
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t1_retired", 64'(retired), 64'd1);

    // HI/LO bypass then architectural hold.
    drive(1, 5'd0, 0, 32'h0, 32'h11, 32'h22, 1);
    cycle();
    chk("t2_hi_bypass", 64'(hi), 64'h11);
    chk("t2_lo_bypass", 64'(lo), 64'h22);
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t2_hi_reg", 64'(hi), 64'h11);

    // Bubble insert, then hold for three cycles, then release.
    stall = 2'b01;
    drive(1, 5'd9, 1, 32'h99, 32'h0, 32'h0, 0);
    cycle();
    chk("t3_bubble_wreg", 64'(wb_wreg), 64'd0);
    chk("t3_retired", 64'(retired), 64'd2);
    stall = 2'b00;
    drive(1, 5'd7, 1, 32'h77, 32'h55, 32'h66, 1);
    cycle();
    stall = 2'b11;
    drive(1, 5'd3, 1, 32'h33, 32'hAA, 32'hBB, 1);
    repeat (3) cycle();
    chk("t3_hold_wd", 64'(wb_wd), 64'd7);
    chk("t3_hold_retired", 64'(retired), 64'd2);
    stall = 2'b00;
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t3_release_retired", 64'(retired), 64'd3);

    // Flush: WB instruction still commits, MEM instruction is discarded.
    drive(1, 5'd1, 0, 32'h0, 32'h33, 32'h0, 1);
    cycle();
    flush = 1'b1;
    drive(1, 5'd2, 0, 32'h0, 32'h44, 32'h0, 1);
    cycle();
    flush = 1'b0;
    chk("t4_hi", 64'(hi), 64'h33);
    chk("t4_valid", 64'(wb_valid), 64'd0);
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t4_hi_after", 64'(hi), 64'h33);

    // Invalid MEM slot masks write enables.
    drive(0, 5'd4, 1, 32'h12, 32'h34, 32'h56, 1);
    cycle();
    chk("t5_wreg", 64'(wb_wreg), 64'd0);
    chk("t5_whilo", 64'(wb_whilo), 64'd0);
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t5_retired", 64'(retired), 64'd4);

    // Counter wrap on the 4-bit instance.
    async_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 5'(i), 1, 32'(i), 32'h0, 32'h0, 0);
      cycle();
    end
    drive(0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0);
    cycle();
    chk("t6_wrap", 64'(d4_retired), 64'd1);
    chk("t6_full", 64'(retired), 64'd17);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      stall = (r == 2) ? 2'b01 : (r == 3) ? 2'b11 : 2'b00;
      flush = ($urandom_range(0, 9) == 0);
      drive(1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom,
            $urandom, 1'($urandom));
      cycle();
      if (i == 200) async_reset();
    end

    stall = 2'b00;
    flush = 1'b0;
    async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
